// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - VGA receive-side timing recovery, lock tracking and pixel coordinate decode
module vga_sync_decoder #(
    parameter int H_START     = 144,
    parameter int H_ACT       = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_START     = 35,
    parameter int V_ACT       = 480,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iVGA_HS,
    input  logic        iVGA_VS,
    input  logic [3:0]  iVGA_R,
    input  logic [3:0]  iVGA_G,
    input  logic [3:0]  iVGA_B,
    output logic [10:0] oX,
    output logic [10:0] oY,
    output logic [3:0]  oR,
    output logic [3:0]  oG,
    output logic [3:0]  oB,
    output logic        oPix_Valid,
    output logic [10:0] oLine_Len,
    output logic [10:0] oFrame_Lines,
    output logic        oLocked,
    output logic        oErr
);

    localparam logic [10:0] H_LO    = 11'(H_START);
    localparam logic [10:0] H_HI    = 11'(H_START + H_ACT - 1);
    localparam logic [10:0] H_TOT   = 11'(H_TOTAL);
    localparam logic [10:0] V_LO    = 11'(V_START);
    localparam logic [10:0] V_HI    = 11'(V_START + V_ACT - 1);
    localparam logic [10:0] V_TOT   = 11'(V_TOTAL);
    localparam logic [10:0] CNT_MAX = 11'h7ff;
    localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        UNLOCKED,
        ACQUIRE,
        LOCKED
    } state_t;

    state_t      state;
    logic [3:0]  good_cnt;
    logic        hs_d;
    logic        vs_d;
    logic [10:0] h_off;
    logic [10:0] v_cnt;
    logic        first_hs;
    logic        first_vs;
    logic        bad_seen;

    logic hs_fall;
    logic vs_fall;
    logic line_bad;
    logic frame_good;
    logic frame_bad;
    logic active;

    assign hs_fall    = hs_d & ~iVGA_HS;
    assign vs_fall    = vs_d & ~iVGA_VS;
    assign line_bad   = hs_fall && first_hs && (h_off != H_TOT);
    // The line closed by a simultaneous HS fall still belongs to the frame being judged.
    assign frame_good = (v_cnt == V_TOT) && !bad_seen && !line_bad;
    assign frame_bad  = vs_fall && first_vs && !frame_good;
    assign active     = (h_off >= H_LO) && (h_off <= H_HI) &&
                        (v_cnt >= V_LO) && (v_cnt <= V_HI) &&
                        (state == LOCKED) && first_hs;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state        <= UNLOCKED;
            good_cnt     <= 4'd0;
            hs_d         <= 1'b1;
            vs_d         <= 1'b1;
            h_off        <= 11'd0;
            v_cnt        <= 11'd0;
            first_hs     <= 1'b0;
            first_vs     <= 1'b0;
            bad_seen     <= 1'b0;
            oX           <= 11'd0;
            oY           <= 11'd0;
            oR           <= 4'd0;
            oG           <= 4'd0;
            oB           <= 4'd0;
            oPix_Valid   <= 1'b0;
            oLine_Len    <= 11'd0;
            oFrame_Lines <= 11'd0;
            oLocked      <= 1'b0;
            oErr         <= 1'b0;
        end else begin
            hs_d <= iVGA_HS;
            vs_d <= iVGA_VS;

            if (hs_fall) begin
                h_off    <= 11'd1;
                first_hs <= 1'b1;
            end else if (h_off != CNT_MAX) begin
                h_off <= h_off + 11'd1;
            end

            if (hs_fall && first_hs) begin
                oLine_Len <= h_off;
            end

            if (vs_fall && hs_fall) begin
                v_cnt <= 11'd1;
            end else if (vs_fall) begin
                v_cnt <= 11'd0;
            end else if (hs_fall && v_cnt != CNT_MAX) begin
                v_cnt <= v_cnt + 11'd1;
            end

            if (vs_fall) begin
                first_vs <= 1'b1;
                bad_seen <= 1'b0;
                if (first_vs) begin
                    oFrame_Lines <= v_cnt;
                end
            end else if (line_bad) begin
                bad_seen <= 1'b1;
            end

            case (state)
                UNLOCKED: begin
                    if (vs_fall) begin
                        state    <= ACQUIRE;
                        good_cnt <= 4'd0;
                    end
                end
                ACQUIRE: begin
                    if (line_bad || frame_bad) begin
                        good_cnt <= 4'd0;
                    end else if (vs_fall) begin
                        good_cnt <= good_cnt + 4'd1;
                        if (good_cnt + 4'd1 == LOCK_N) begin
                            state   <= LOCKED;
                            oLocked <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (line_bad || frame_bad) begin
                        state    <= ACQUIRE;
                        good_cnt <= 4'd0;
                        oLocked  <= 1'b0;
                        oErr     <= 1'b1;
                    end
                end
                default: begin
                    state    <= UNLOCKED;
                    good_cnt <= 4'd0;
                    oLocked  <= 1'b0;
                end
            endcase

            // Coordinates and colour hold their last values outside the active window.
            oPix_Valid <= active;
            if (active) begin
                oX <= h_off - H_LO;
                oY <= v_cnt - V_LO;
                oR <= iVGA_R;
                oG <= iVGA_G;
                oB <= iVGA_B;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - self-checking bench for vga_sync_decoder with scaled-down timing
module tb_vga_sync_decoder;

    localparam int H_START  = 10;
    localparam int H_ACT    = 24;
    localparam int H_TOTAL  = 40;
    localparam int V_START  = 4;
    localparam int V_ACT    = 12;
    localparam int V_TOTAL  = 20;
    localparam int LOCK_FR  = 2;
    localparam int HS_W     = 4;
    localparam int VS_LINES = 2;
    localparam int RST_POS  = 15;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iVGA_HS;
    logic        iVGA_VS;
    logic [3:0]  iVGA_R;
    logic [3:0]  iVGA_G;
    logic [3:0]  iVGA_B;
    logic [10:0] oX;
    logic [10:0] oY;
    logic [3:0]  oR;
    logic [3:0]  oG;
    logic [3:0]  oB;
    logic        oPix_Valid;
    logic [10:0] oLine_Len;
    logic [10:0] oFrame_Lines;
    logic        oLocked;
    logic        oErr;

    vga_sync_decoder #(
        .H_START(H_START), .H_ACT(H_ACT), .H_TOTAL(H_TOTAL),
        .V_START(V_START), .V_ACT(V_ACT), .V_TOTAL(V_TOTAL),
        .LOCK_FRAMES(LOCK_FR)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iVGA_HS(iVGA_HS), .iVGA_VS(iVGA_VS),
        .iVGA_R(iVGA_R), .iVGA_G(iVGA_G), .iVGA_B(iVGA_B),
        .oX(oX), .oY(oY), .oR(oR), .oG(oG), .oB(oB),
        .oPix_Valid(oPix_Valid), .oLine_Len(oLine_Len),
        .oFrame_Lines(oFrame_Lines), .oLocked(oLocked), .oErr(oErr)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        int lines;
        int bad_line;
        int bad_len;
        int rst_line;
        int exp_bad_ll;
        int exp_pulses;
        bit exp_locked;
        bit exp_err;
        int exp_ll;
        int exp_fl;
        bit chk_last;
    } vec_t;

    vec_t vecs[$];

    int n_cmp = 0;
    int n_bad = 0;
    int frame_pulses;

    // Reference model: event-level view of lines and frames as the generator produced them.
    bit          m_first, m_acq, m_locked, m_err, m_bad_frame;
    int          m_cnt, m_falls, m_prev_len;
    logic [10:0] m_ll, m_fl, lx, ly;
    logic [3:0]  lr, lg, lb;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input int lines, input int bad_line, input int bad_len, input int rst_line,
                           input int exp_bad_ll, input int exp_pulses, input bit exp_locked,
                           input bit exp_err, input int exp_ll, input int exp_fl, input bit chk_last);
        vec_t v;
        v.lines = lines; v.bad_line = bad_line; v.bad_len = bad_len; v.rst_line = rst_line;
        v.exp_bad_ll = exp_bad_ll; v.exp_pulses = exp_pulses; v.exp_locked = exp_locked;
        v.exp_err = exp_err; v.exp_ll = exp_ll; v.exp_fl = exp_fl; v.chk_last = chk_last;
        vecs.push_back(v);
    endtask

    task automatic m_reset();
        m_first = 0; m_acq = 0; m_locked = 0; m_err = 0; m_bad_frame = 0;
        m_cnt = 0; m_falls = 0; m_prev_len = 0;
        m_ll = '0; m_fl = '0; lx = '0; ly = '0; lr = '0; lg = '0; lb = '0;
    endtask

    task automatic m_hs_fall(input bit line0, input int len);
        int meas;
        bit line_bad;
        bit good;
        meas     = (m_prev_len > 2047) ? 2047 : m_prev_len;
        line_bad = m_first && (meas != H_TOTAL);
        if (m_first) m_ll = 11'(meas);
        m_first    = 1;
        m_prev_len = len;
        good = (m_falls == V_TOTAL) && !m_bad_frame && !line_bad;
        if (line0 && m_acq) m_fl = 11'(m_falls);
        if (!m_acq) begin
            if (line0) begin
                m_acq = 1;
                m_cnt = 0;
            end
        end else if (line_bad || (line0 && !good)) begin
            m_err    = m_err | m_locked;
            m_locked = 0;
            m_cnt    = 0;
        end else if (line0 && !m_locked) begin
            m_cnt++;
            if (m_cnt == LOCK_FR) m_locked = 1;
        end
        if (line0) begin
            m_falls     = 1;
            m_bad_frame = 0;
        end else begin
            if (m_falls < 2047) m_falls++;
            if (line_bad) m_bad_frame = 1;
        end
    endtask

    task automatic step(input int p, input int len, input bit line0, input bit vs_low, input bit rst);
        bit ev;
        logic [3:0] r, g, b;
        r = 4'($urandom);
        g = 4'($urandom);
        b = 4'($urandom);
        iVGA_HS = (p < HS_W) ? 1'b0 : 1'b1;
        iVGA_VS = vs_low ? 1'b0 : 1'b1;
        iVGA_R  = r;
        iVGA_G  = g;
        iVGA_B  = b;
        iRST    = rst;
        ev = !rst && m_locked && m_first && (p >= H_START) && (p < H_START + H_ACT) &&
             (m_falls >= V_START) && (m_falls < V_START + V_ACT);
        if (ev) begin
            lx = 11'(p - H_START);
            ly = 11'(m_falls - V_START);
            lr = r; lg = g; lb = b;
        end
        if (rst) m_reset();
        else if (p == 0) m_hs_fall(line0, len);
        @(posedge iCLK);
        #1;
        check("pix_valid", 64'(oPix_Valid), 64'(ev));
        check("pix_data", 64'({oX, oY, oR, oG, oB}), 64'({lx, ly, lr, lg, lb}));
        check("status", 64'({oLocked, oErr, oLine_Len, oFrame_Lines}),
              64'({m_locked, m_err, m_ll, m_fl}));
        if (rst) begin
            check("reset_mid_zero", 64'({oX, oY, oR, oG, oB, oPix_Valid, oLine_Len, oFrame_Lines, oLocked, oErr}), 64'd0);
        end
        if (oPix_Valid) frame_pulses++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //      lines bad  badlen rst  badll pulses lk err ll  fl  last
        add_vec(20,   -1,  0,     -1,  0,    0,     0, 0,  40, 0,  0);
        add_vec(20,   -1,  0,     -1,  0,    0,     0, 0,  40, 20, 0);
        add_vec(20,   -1,  0,     -1,  0,    288,   1, 0,  40, 20, 0);
        add_vec(20,   -1,  0,     -1,  0,    288,   1, 0,  40, 20, 1);
        add_vec(20,   5,   39,    -1,  39,   72,    0, 1,  40, 20, 0);
        add_vec(20,   -1,  0,     -1,  0,    0,     0, 1,  40, 20, 0);
        add_vec(20,   -1,  0,     -1,  0,    0,     0, 1,  40, 20, 0);
        add_vec(20,   -1,  0,     -1,  0,    288,   1, 1,  40, 20, 0);
        add_vec(19,   -1,  0,     -1,  0,    288,   1, 1,  40, 20, 0);
        add_vec(20,   -1,  0,     -1,  0,    0,     0, 1,  40, 19, 0);
        add_vec(20,   -1,  0,     -1,  0,    0,     0, 1,  40, 20, 0);
        add_vec(20,   -1,  0,     -1,  0,    288,   1, 1,  40, 20, 0);
        add_vec(20,   -1,  0,     8,   0,    125,   0, 0,  40, 0,  0);
        add_vec(20,   -1,  0,     -1,  0,    0,     0, 0,  40, 0,  0);
        add_vec(20,   -1,  0,     -1,  0,    0,     0, 0,  40, 20, 0);
        add_vec(20,   -1,  0,     -1,  0,    288,   1, 0,  40, 20, 0);
        add_vec(20,   3,   3004,  -1,  2047, 24,    0, 1,  40, 20, 0);
        add_vec(20,   -1,  0,     -1,  0,    0,     0, 1,  40, 20, 0);

        iRST = 1'b1; iVGA_HS = 1'b1; iVGA_VS = 1'b1;
        iVGA_R = '0; iVGA_G = '0; iVGA_B = '0;
        m_reset();
        repeat (3) @(posedge iCLK);
        #1;
        check("reset_state", 64'({oX, oY, oR, oG, oB, oPix_Valid, oLine_Len, oFrame_Lines, oLocked, oErr}), 64'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            frame_pulses = 0;
            for (int k = 0; k < vecs[i].lines; k++) begin
                int len;
                len = (k == vecs[i].bad_line) ? vecs[i].bad_len : H_TOTAL;
                for (int p = 0; p < len; p++) begin
                    step(p, len, k == 0, k < VS_LINES, (k == vecs[i].rst_line) && (p == RST_POS));
                    if (vecs[i].bad_line >= 0 && k == vecs[i].bad_line + 1 && p == 0) begin
                        check("bad_line_len", 64'(oLine_Len), 64'(vecs[i].exp_bad_ll));
                        check("bad_line_unlock", 64'({oLocked, oErr}), 64'b01);
                    end
                end
            end
            check($sformatf("frame%0d_pulses", i), 64'(frame_pulses), 64'(vecs[i].exp_pulses));
            check($sformatf("frame%0d_status", i), 64'({oLocked, oErr, oLine_Len, oFrame_Lines}),
                  64'({vecs[i].exp_locked, vecs[i].exp_err, 11'(vecs[i].exp_ll), 11'(vecs[i].exp_fl)}));
            if (vecs[i].chk_last) begin
                check("last_pixel_xy", 64'({oX, oY}), 64'({11'(H_ACT - 1), 11'(V_ACT - 1)}));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the team's 640x480 VGA timing generator.
- Samples active-low HS/VS and 4:4:4 RGB on the pixel clock, measures line and frame timing, and declares lock.
- Recovers X/Y pixel coordinates with a registered pixel-valid strobe.
- Used as the on-chip frame-capture front end and as the self-check monitor on the generator's output.

Parameters:
H_START, 144, clocks from HS falling-edge sample to first active pixel (sync + back porch)
H_ACT, 640, active pixels per line
H_TOTAL, 800, expected clocks between consecutive HS falls
V_START, 35, HS-fall count after VS fall at which the first active line begins
V_ACT, 480, active lines per frame
V_TOTAL, 525, expected HS falls between consecutive VS falls
LOCK_FRAMES, 2, consecutive good frames required to assert lock (1..15)

Ports:
iCLK  in  1  pixel clock
iRST  in  1  synchronous reset, active-high
iVGA_HS  in  1  horizontal sync, active low
iVGA_VS  in  1  vertical sync, active low
iVGA_R  in  4  red sample
iVGA_G  in  4  green sample
iVGA_B  in  4  blue sample
oX  out  11  recovered column 0..H_ACT-1
oY  out  11  recovered row 0..V_ACT-1
oR  out  4  registered red, aligned with oX/oY
oG  out  4  registered green
oB  out  4  registered blue
oPix_Valid  out  1  pixel strobe (active pixel while locked)
oLine_Len  out  11  last measured HS-fall-to-HS-fall length
oFrame_Lines  out  11  last measured HS falls per frame
oLocked  out  1  timing lock
oErr  out  1  sticky timing error

Behaviour:
- Reset: all outputs and internal counters 0; HS/VS history registers set to 1 (idle high), so no edge is seen on the first post-reset sample.
- Reset mid-frame: the same state is applied; lock must be re-acquired from scratch.
- Edge detect: HS fall = previous sample 1 and current sample 0. VS fall is detected the same way.
- h_off (11 b): on an HS fall, set to 1; otherwise increment, saturating at 2047. h_off therefore equals the offset of the current sample from the last HS fall. A first-HS-seen flag is set on the first HS fall.
- Line length: on an HS fall with the flag already set, oLine_Len <= h_off. A bad line is one with h_off != H_TOTAL.
- v_cnt (11 b): on a VS fall, set to 0. On an HS fall, increment, saturating at 2047.
- Simultaneous VS and HS fall: v_cnt <= 1 (the HS fall belongs to the new frame). Frame measurement uses the pre-update value.
- Frame measurement: on a VS fall after the first VS fall, oFrame_Lines <= v_cnt. A frame is good if v_cnt == V_TOTAL and no bad line occurred since the previous VS fall.
- Lock FSM states:
  - UNLOCKED: no lock.
  - ACQUIRE: counts good frames, 4-bit counter.
  - LOCKED: lock held.
- Lock FSM transitions:
  - UNLOCKED -> ACQUIRE on the first VS fall.
  - ACQUIRE: a good frame increments the count; on reaching LOCK_FRAMES, go to LOCKED. A bad frame or bad line clears the count and stays in ACQUIRE.
  - LOCKED -> ACQUIRE on any bad line, checked immediately at that HS fall, or any bad frame; the count is cleared.
- oLocked = (state == LOCKED), registered.
- oErr is set on any bad line or bad frame detected while LOCKED. It is cleared only by iRST.
- Active region, evaluated on the current sample:
  - h_off in [H_START, H_START+H_ACT-1]
  - v_cnt in [V_START, V_START+V_ACT-1]
  - state == LOCKED
  - first-HS flag set
- Outputs, latency 1 clock:
  - Next cycle: oPix_Valid <= active; oX <= h_off-H_START; oY <= v_cnt-V_START; oR/oG/oB <= iVGA_R/G/B.
  - When not active: oPix_Valid <= 0; oX/oY/oR/oG/oB hold their last values.
- Arithmetic: all counters are 11-bit unsigned. The subtractions are only used while active, so they never underflow.
- Saturation: with no sync for 2047 clocks or lines, the counter holds at 2047. The next edge yields a bad-length measurement, which drops lock.

Test Plan:
- Reset, then nominal generator timing (HS low 96 clk every 800, VS low 2 lines every 525) for 3 frames:
  - oLocked rises at the VS fall ending good frame 2.
  - oLine_Len=800, oFrame_Lines=525, oErr=0.
- Locked frame with a ramp pixel pattern R=X[3:0]:
  - First oPix_Valid pulse occurs 1 clk after sample h_off=144, v_cnt=35, with oX=0, oY=0.
  - Last pulse: oX=639, oY=479.
  - Exactly 307200 pulses per frame.
- One line shortened to 799 clk while locked:
  - At that HS fall, oLocked drops and oErr=1 (sticky), with oLine_Len=799.
  - Relock takes 2 further good frames; oErr remains 1.
- Frame with 524 lines: oFrame_Lines=524, lock lost.
- Simultaneous HS and VS fall:
  - v_cnt=1 on the next cycle.
  - The frame is judged on the old count 525 and stays good.
- iRST pulse mid-active line while locked:
  - The next cycle shows all outputs 0.
  - No oPix_Valid until 2 good frames complete after the first post-reset VS fall.
- HS held high for 3000 clk:
  - h_off saturates at 2047.
  - At the next HS fall, oLine_Len=2047 and lock is lost.
